div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- Iterative multi-cycle divider controller serving the execute stage's DIV/DIVU path.
- Accepts operands plus a start request from the execute stage and runs a 32-step restoring division FSM.
- Returns a 64-bit {remainder, quotient} result with a ready flag.
- Supports annulment when the instruction is flushed (exception or mispredict), and drives a busy indication the execute stage uses to hold its stall request.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH, iteration count is WIDTH.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i.
- opdata1_i  input  WIDTH  dividend; sampled with start_i.
- opdata2_i  input  WIDTH  divisor; sampled with start_i.
- start_i  input  1  division request; level, held high by the requester until it has consumed ready_o.
- annul_i  input  1  cancel the in-flight or pending operation.
- result_o  output  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}; registered.
- ready_o  output  1  result_o valid; registered.
- busy_o  output  1  FSM in BYZERO or RUN; registered-state decode.

Behaviour:
- Reset: when rst=1 at an edge, state <= IDLE, cnt <= 0, result_o <= 0, ready_o <= 0. Reset mid-operation discards all progress; busy_o is 0 the following cycle.
- States: IDLE, BYZERO, RUN, DONE.
- IDLE
  - start_i=1 and annul_i=0 at edge ending cycle N:
    - opdata2_i==0 -> BYZERO.
    - Otherwise -> RUN. Latch |dividend| and |divisor| (two's-complement negate if signed_div_i and MSB=1), signed_div_i, both operand sign bits. Clear cnt and the partial-remainder register.
  - start_i=1 with annul_i=1: ignored, stay IDLE.
  - ready_o=0, result_o=0.
- BYZERO: one cycle. Next state DONE with result_o=0 and ready_o=1, so ready_o is first high in cycle N+2. annul_i=1 -> IDLE instead.
- RUN
  - Per cycle while cnt<WIDTH: shift {rem,quo} left 1; trial subtract divisor from the upper half. If non-negative, keep the difference and set quo LSB=1; else quo LSB=0. cnt <= cnt+1.
  - cnt==WIDTH cycle: apply sign fix.
    - Quotient negated if signed and dividend sign != divisor sign.
    - Remainder negated if signed and dividend negative.
    - Load result_o, set ready_o=1, go DONE.
  - Total: RUN occupies cycles N+1..N+WIDTH+1; ready_o first high in cycle N+WIDTH+2 (N+34 for WIDTH=32).
  - annul_i=1 in any RUN cycle -> IDLE at that edge; ready_o never asserts for that operation.
- DONE
  - ready_o=1 and result_o stable while start_i=1 and annul_i=0.
  - start_i=0 or annul_i=1 -> IDLE; ready_o and result_o cleared at that edge.
  - A new start is accepted only from IDLE, so back-to-back divides need one IDLE cycle between them.
- Arithmetic
  - Signed INT_MIN / -1 wraps: quotient 0x80000000, remainder 0. No exception.
  - Unsigned operands are used unmodified.
  - Subtraction is WIDTH+1 bits wide to detect the borrow.
- Simultaneous events: rst has priority over annul_i, and annul_i has priority over start_i and over completion. Changes to the operand inputs after acceptance have no effect.
- busy_o = (state==BYZERO)||(state==RUN). The execute stage stalls on start_i && !ready_o.

Test Plan:
- Unsigned 100/7: signed_div_i=0, start_i held from cycle N -> ready_o first high in cycle N+34, result_o={0x00000002,0x0000000E}; busy_o high N+1..N+33.
- Signed -7/2 (0xFFFFFFF9, 0x00000002) -> result_o={0xFFFFFFFF,0xFFFFFFFD} at N+34. Signed 7/-2 -> {0x00000001,0xFFFFFFFD}.
- Divide by zero: opdata2_i=0 -> ready_o high at N+2, result_o=0; drop start_i -> ready_o=0 the next cycle.
- Annul: start at N, annul_i=1 in cycle N+10 -> IDLE in N+11, busy_o=0, ready_o stays 0. New start of 9/3 at N+12 -> {0,3} at N+46.
- Overflow: signed 0x80000000 / 0xFFFFFFFF -> result_o={0x00000000,0x80000000}. Unsigned 0xFFFFFFFF/1 -> {0,0xFFFFFFFF}.
- rst=1 in cycle N+5 of a run -> cycle N+6: ready_o=0, busy_o=0, result_o=0. start_i still high -> new operation accepted from IDLE, ready_o at N+6+34.

Source files
------------

// File: rtl/div_ctrl.sv
// Iterative restoring divider controller for the execute stage DIV/DIVU path.
// One quotient bit per cycle; signs are stripped on entry and restored on the final RUN cycle.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {IDLE, BYZERO, RUN, DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] abs_cond(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? neg2c(x) : x;
  endfunction

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvsr;
  logic             sdiv, sgn1, sgn2;
  logic             accept;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign accept = (state == IDLE) && start_i && !annul_i;
  assign busy_o = (state == BYZERO) || (state == RUN);

  // Partial remainder shifts in the dividend MSB; a clear top bit of the difference means no borrow.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr};
    q_fix   = (sdiv && (sgn1 ^ sgn2)) ? neg2c(quo) : quo;
    r_fix   = (sdiv && sgn1) ? neg2c(rem) : rem;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (opdata2_i == '0) ? BYZERO : RUN;
      BYZERO:  state_nxt = annul_i ? IDLE : DONE;
      RUN: begin
        if (annul_i)           state_nxt = IDLE;
        else if (cnt == LAST)  state_nxt = DONE;
      end
      DONE:    if (!start_i || annul_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt      <= '0;
          result_o <= '0;
          ready_o  <= 1'b0;
        end
        BYZERO: begin
          if (!annul_i) begin
            result_o <= '0;
            ready_o  <= 1'b1;
          end
        end
        RUN: begin
          if (!annul_i) begin
            if (cnt == LAST) begin
              result_o <= {r_fix, q_fix};
              ready_o  <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        DONE: begin
          if (!start_i || annul_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers: loaded on acceptance, so they need no reset
  always_ff @(posedge clk) begin
    if (accept && (opdata2_i != '0)) begin
      rem  <= '0;
      quo  <= abs_cond(opdata1_i, signed_div_i);
      dvsr <= abs_cond(opdata2_i, signed_div_i);
      sdiv <= signed_div_i;
      sgn1 <= opdata1_i[WIDTH-1];
      sgn2 <= opdata2_i[WIDTH-1];
    end else if ((state == RUN) && (cnt != LAST)) begin
      if (!trial[WIDTH]) begin
        rem <= trial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= shifted[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, sign handling, divide-by-zero, annul and reset.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst, signed_div_i, start_i, annul_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o, busy_o;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  div_ctrl #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start in the current cycle N, expect ready at N+34, hold one cycle, then release.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    step();
    opdata1_i    = 32'h1357_9BDF;
    opdata2_i    = 32'h0;
    signed_div_i = ~sgn;
    chk({tag, "_busy_n1"}, busy_o, 1'b1);
    for (int k = 2; k <= 33; k++) step();
    chk({tag, "_busy_n33"}, busy_o, 1'b1);
    chk({tag, "_ready_n33"}, ready_o, 1'b0);
    step();
    chk({tag, "_ready_n34"}, ready_o, 1'b1);
    chk({tag, "_result"}, result_o, exp);
    chk({tag, "_busy_n34"}, busy_o, 1'b0);
    step();
    chk({tag, "_hold_ready"}, ready_o, 1'b1);
    chk({tag, "_hold_result"}, result_o, exp);
    start_i = 1'b0;
    step();
    chk({tag, "_drop_ready"}, ready_o, 1'b0);
    chk({tag, "_drop_result"}, result_o, 64'h0);
  endtask

  initial begin
    rst = 1'b1; signed_div_i = 1'b0; start_i = 1'b0; annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset_ready", ready_o, 1'b0);
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_result", result_o, 64'h0);

    run_div("u100_7", 1'b0, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E});
    run_div("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div("s7_-2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD});
    run_div("s-100_-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'h0000_000E});
    run_div("u7_100", 1'b0, 32'd7, 32'd100, {32'h0000_0007, 32'h0000_0000});
    run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});
    run_div("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, {32'h0000_0000, 32'hFFFF_FFFF});

    // Divide by zero
    signed_div_i = 1'b0; opdata1_i = 32'd55; opdata2_i = 32'd0; start_i = 1'b1;
    step();
    chk("dz_busy_n1", busy_o, 1'b1);
    chk("dz_ready_n1", ready_o, 1'b0);
    step();
    chk("dz_ready_n2", ready_o, 1'b1);
    chk("dz_result", result_o, 64'h0);
    chk("dz_busy_n2", busy_o, 1'b0);
    start_i = 1'b0;
    step();
    chk("dz_drop_ready", ready_o, 1'b0);

    // Annul in RUN cycle N+10, restart at N+12
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    for (int k = 1; k <= 10; k++) step();
    chk("an_busy_n10", busy_o, 1'b1);
    annul_i = 1'b1;
    step();
    chk("an_busy_n11", busy_o, 1'b0);
    chk("an_ready_n11", ready_o, 1'b0);
    annul_i = 1'b0; start_i = 1'b0;
    step();
    chk("an_ready_n12", ready_o, 1'b0);
    run_div("an_9_3", 1'b0, 32'd9, 32'd3, {32'h0000_0000, 32'h0000_0003});

    // Annul together with start from IDLE is ignored
    opdata1_i = 32'd9; opdata2_i = 32'd3; start_i = 1'b1; annul_i = 1'b1;
    step();
    chk("an_idle_busy", busy_o, 1'b0);
    start_i = 1'b0; annul_i = 1'b0;
    step();

    // Reset in cycle N+5, start held so the operation restarts at N+6
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    for (int k = 1; k <= 5; k++) step();
    chk("rst_busy_n5", busy_o, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_ready_n6", ready_o, 1'b0);
    chk("rst_busy_n6", busy_o, 1'b0);
    chk("rst_result_n6", result_o, 64'h0);
    run_div("rst_restart", 1'b0, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
